// File: rtl/idma_legalizer_burst_pkg.sv
// Shared types and constants for the iDMA burst read/write legalizer.
// The optional zero-length discard is enabled with the IDMA_LEGALIZER_ZERO_LEN_EN macro.
package idma_legalizer_burst_pkg;

  localparam int unsigned StrbWidth     = 8;
  localparam int unsigned OffsetWidth   = $clog2(StrbWidth);
  localparam int unsigned XferAddrWidth = 32;
  localparam int unsigned XferLenWidth  = 32;

  // One queued 1D transfer as accepted on the request port.
  typedef struct packed {
    logic [XferLenWidth-1:0]  length;
    logic [XferAddrWidth-1:0] src;
    logic [XferAddrWidth-1:0] dst;
    logic                     decouple;
  } req_entry_t;

  // Mutable progress of one side (read or write) through the active transfer.
  typedef struct packed {
    logic [XferAddrWidth-1:0] addr;
    logic [XferLenWidth-1:0]  remaining;
    logic                     live;
  } side_xfer_t;

endpackage

// File: rtl/idma_legalizer_burst_side.sv
// Burst shaping for one side: bytes to the next boundary, burst size, beat count,
// first-beat offset, tailer and last flag for the current address and remaining length.
module idma_legalizer_burst_side #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned LenWidth  = 32,
  parameter int unsigned OffW      = 3,
  parameter int unsigned MaxBeats  = 16,
  parameter int unsigned PageSize  = 4096
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [AddrWidth-1:0] peer_addr,
  input  logic [LenWidth-1:0]  remaining,
  input  logic                 decouple,
  output logic [AddrWidth-1:0] burst_addr,
  output logic [LenWidth-1:0]  nbytes,
  output logic [7:0]           len,
  output logic [OffW-1:0]      offset,
  output logic [OffW-1:0]      tailer,
  output logic                 last
);

  localparam int unsigned BurstBytes = MaxBeats * (2 ** OffW);
  localparam int unsigned Bound      = (PageSize < BurstBytes) ? PageSize : BurstBytes;

  function automatic logic [LenWidth-1:0] to_bound(input logic [AddrWidth-1:0] a);
    return LenWidth'(Bound) - LenWidth'(a & AddrWidth'(Bound - 1));
  endfunction

  logic [LenWidth-1:0] own_bpb;
  logic [LenWidth-1:0] peer_bpb;
  logic [LenWidth-1:0] possible;
  logic [LenWidth-1:0] span;

  // Coupled transfers must cut both sides at the nearer of the two boundaries.
  always_comb begin
    own_bpb    = to_bound(addr);
    peer_bpb   = to_bound(peer_addr);
    possible   = (decouple || (own_bpb <= peer_bpb)) ? own_bpb : peer_bpb;
    last       = (remaining <= possible);
    nbytes     = last ? remaining : possible;
    offset     = addr[OffW-1:0];
    span       = nbytes + LenWidth'(offset);
    tailer     = span[OffW-1:0];
    len        = (span == '0) ? 8'd0 : 8'((span - LenWidth'(1)) >> OffW);
    burst_addr = {addr[AddrWidth-1:OffW], {OffW{1'b0}}};
  end

endmodule

// File: rtl/idma_legalizer_burst_rw.sv
// iDMA read/write legalizer: queues 1D transfers and splits them into AXI-style bursts.
// Define IDMA_LEGALIZER_ZERO_LEN_EN to discard zero-length requests and pulse zero_len_o.
module idma_legalizer_burst_rw
  import idma_legalizer_burst_pkg::*;
#(
  parameter int unsigned DataWidth    = 8 * StrbWidth,
  parameter int unsigned AddrWidth    = XferAddrWidth,
  parameter int unsigned LenWidth     = XferLenWidth,
  parameter int unsigned MaxBeats     = 16,
  parameter int unsigned PageSize     = 4096,
  parameter int unsigned ReqFifoDepth = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [LenWidth-1:0]              req_length_i,
  input  logic [AddrWidth-1:0]             req_src_addr_i,
  input  logic [AddrWidth-1:0]             req_dst_addr_i,
  input  logic                             req_decouple_i,
  output logic                             r_valid_o,
  input  logic                             r_ready_i,
  output logic [AddrWidth-1:0]             r_addr_o,
  output logic [7:0]                       r_len_o,
  output logic [$clog2(DataWidth/8)-1:0]   r_offset_o,
  output logic [$clog2(DataWidth/8)-1:0]   r_tailer_o,
  output logic                             r_last_o,
  output logic                             w_valid_o,
  input  logic                             w_ready_i,
  output logic [AddrWidth-1:0]             w_addr_o,
  output logic [7:0]                       w_len_o,
  output logic [$clog2(DataWidth/8)-1:0]   w_offset_o,
  output logic [$clog2(DataWidth/8)-1:0]   w_tailer_o,
  output logic                             w_last_o,
  input  logic                             flush_i,
  input  logic                             kill_i,
  output logic                             r_busy_o,
  output logic                             w_busy_o
`ifdef IDMA_LEGALIZER_ZERO_LEN_EN
  ,
  output logic                             zero_len_o
`endif
);

  localparam int unsigned OffW = $clog2(DataWidth / 8);
  localparam int unsigned PtrW = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
  localparam int unsigned CntW = $clog2(ReqFifoDepth + 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(ReqFifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  req_entry_t           fifo_q [ReqFifoDepth];
  req_entry_t           head;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 push, load, fifo_empty, head_zero;
  side_xfer_t           r_q, w_q;
  logic                 dec_q;
  logic [LenWidth-1:0]  r_nbytes, w_nbytes;
  logic                 r_last, w_last, r_done, w_done;

  assign head        = fifo_q[rd_ptr_q];
  assign fifo_empty  = (count_q == '0);
  assign req_ready_o = (count_q != CntW'(ReqFifoDepth));
  assign push        = req_valid_i & req_ready_o;

`ifdef IDMA_LEGALIZER_ZERO_LEN_EN
  assign head_zero = (head.length == '0);
`else
  assign head_zero = 1'b0;
`endif

  // Valid is qualified by ready; a coupled transfer needs both readies so the sides stay in lockstep.
  assign r_valid_o = r_q.live & r_ready_i & (dec_q | w_ready_i) & ~flush_i;
  assign w_valid_o = w_q.live & w_ready_i & (dec_q | r_ready_i) & ~flush_i;
  assign r_done    = ~r_q.live | (r_valid_o & r_last);
  assign w_done    = ~w_q.live | (w_valid_o & w_last);
  assign load      = r_done & w_done & ~fifo_empty & ~kill_i & ~flush_i;
  assign r_last_o  = r_q.live & r_last;
  assign w_last_o  = w_q.live & w_last;
  assign r_busy_o  = r_q.live;
  assign w_busy_o  = w_q.live;

  idma_legalizer_burst_side #(
    .AddrWidth(AddrWidth), .LenWidth(LenWidth), .OffW(OffW),
    .MaxBeats(MaxBeats), .PageSize(PageSize)
  ) i_read_side (
    .addr(r_q.addr), .peer_addr(w_q.addr), .remaining(r_q.remaining), .decouple(dec_q),
    .burst_addr(r_addr_o), .nbytes(r_nbytes), .len(r_len_o),
    .offset(r_offset_o), .tailer(r_tailer_o), .last(r_last)
  );

  idma_legalizer_burst_side #(
    .AddrWidth(AddrWidth), .LenWidth(LenWidth), .OffW(OffW),
    .MaxBeats(MaxBeats), .PageSize(PageSize)
  ) i_write_side (
    .addr(w_q.addr), .peer_addr(r_q.addr), .remaining(w_q.remaining), .decouple(dec_q),
    .burst_addr(w_addr_o), .nbytes(w_nbytes), .len(w_len_o),
    .offset(w_offset_o), .tailer(w_tailer_o), .last(w_last)
  );

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{length: req_length_i, src: req_src_addr_i,
                            dst: req_dst_addr_i, decouple: req_decouple_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (load) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !load)      count_q <= count_q + CntW'(1);
      else if (!push && load) count_q <= count_q - CntW'(1);
    end
  end

  // Kill beats load; a load overwrites sides that retire their last burst on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q   <= '0;
      w_q   <= '0;
      dec_q <= 1'b0;
    end else if (kill_i) begin
      r_q.live <= 1'b0;
      w_q.live <= 1'b0;
    end else if (load) begin
      r_q   <= '{addr: head.src, remaining: head.length, live: ~head_zero};
      w_q   <= '{addr: head.dst, remaining: head.length, live: ~head_zero};
      dec_q <= head.decouple;
    end else begin
      if (r_valid_o) begin
        r_q.addr      <= r_q.addr + AddrWidth'(r_nbytes);
        r_q.remaining <= r_q.remaining - r_nbytes;
        if (r_last) r_q.live <= 1'b0;
      end
      if (w_valid_o) begin
        w_q.addr      <= w_q.addr + AddrWidth'(w_nbytes);
        w_q.remaining <= w_q.remaining - w_nbytes;
        if (w_last) w_q.live <= 1'b0;
      end
    end
  end

`ifdef IDMA_LEGALIZER_ZERO_LEN_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) zero_len_o <= 1'b0;
    else         zero_len_o <= load & head_zero;
  end
`endif

endmodule

// File: tb/tb_idma_legalizer_burst_rw.sv
// Directed bench for idma_legalizer_burst_rw at default parameters (64-bit data, 16 beats, B = 128).
module tb_idma_legalizer_burst_rw;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_length_i = '0;
  logic [31:0] req_src_addr_i = '0;
  logic [31:0] req_dst_addr_i = '0;
  logic        req_decouple_i = 1'b0;
  logic        r_valid_o, w_valid_o;
  logic        r_ready_i = 1'b1;
  logic        w_ready_i = 1'b1;
  logic [31:0] r_addr_o, w_addr_o;
  logic [7:0]  r_len_o, w_len_o;
  logic [2:0]  r_offset_o, r_tailer_o, w_offset_o, w_tailer_o;
  logic        r_last_o, w_last_o;
  logic        flush_i = 1'b0;
  logic        kill_i = 1'b0;
  logic        r_busy_o, w_busy_o;
`ifdef IDMA_LEGALIZER_ZERO_LEN_EN
  logic        zero_len_o;
`endif

  // Clock / reset
  always #5 clk_i = ~clk_i;

  idma_legalizer_burst_rw dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_length_i(req_length_i),
    .req_src_addr_i(req_src_addr_i), .req_dst_addr_i(req_dst_addr_i), .req_decouple_i(req_decouple_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_addr_o(r_addr_o), .r_len_o(r_len_o),
    .r_offset_o(r_offset_o), .r_tailer_o(r_tailer_o), .r_last_o(r_last_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_addr_o(w_addr_o), .w_len_o(w_len_o),
    .w_offset_o(w_offset_o), .w_tailer_o(w_tailer_o), .w_last_o(w_last_o),
    .flush_i(flush_i), .kill_i(kill_i), .r_busy_o(r_busy_o), .w_busy_o(w_busy_o)
`ifdef IDMA_LEGALIZER_ZERO_LEN_EN
    , .zero_len_o(zero_len_o)
`endif
  );

  typedef struct {
    logic [31:0] length;
    logic [31:0] src;
    logic [31:0] dst;
    logic        dec;
  } req_vec_t;

  typedef struct {
    int          id;
    logic        is_w;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  off;
    logic [2:0]  tail;
    logic        last;
  } burst_vec_t;

  // Scoreboard
  logic [46:0] exp_r_q[$];
  logic [46:0] exp_w_q[$];
  req_vec_t    rt[5];
  burst_vec_t  bt[$];
  int          total = 0;
  int          bad = 0;
  logic        cur_dec = 1'b0;
  logic        r_seen, w_seen;

  function automatic logic [46:0] pack(input logic [31:0] a, input logic [7:0] l,
                                       input logic [2:0] o, input logic [2:0] t, input logic la);
    return {a, l, o, t, la};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    total++;
    bad++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic add_burst(input int id, input logic is_w, input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] o, input logic [2:0] t, input logic la);
    bt.push_back('{id: id, is_w: is_w, addr: a, len: l, off: o, tail: t, last: la});
  endtask

  task automatic expect_pair(input logic [31:0] ra, input logic [31:0] wa, input logic [7:0] l,
                             input logic [2:0] t, input logic la);
    exp_r_q.push_back(pack(ra, l, 3'd0, t, la));
    exp_w_q.push_back(pack(wa, l, 3'd0, t, la));
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic push_req(input logic [31:0] len, input logic [31:0] src, input logic [31:0] dst,
                          input logic dec);
    req_valid_i = 1'b1;
    req_length_i = len;
    req_src_addr_i = src;
    req_dst_addr_i = dst;
    req_decouple_i = dec;
    cur_dec = dec;
  endtask

  task automatic observe();
    #1;
    r_seen = r_valid_o;
    w_seen = w_valid_o;
    if (!cur_dec && (r_valid_o || w_valid_o)) check("coupled_pair", r_valid_o, w_valid_o);
    if (r_valid_o) begin
      if (exp_r_q.size() == 0) fail("r_extra_burst", $sformatf("unexpected burst at 0x%0h", r_addr_o));
      else check("r_burst", pack(r_addr_o, r_len_o, r_offset_o, r_tailer_o, r_last_o), exp_r_q.pop_front());
    end
    if (w_valid_o) begin
      if (exp_w_q.size() == 0) fail("w_extra_burst", $sformatf("unexpected burst at 0x%0h", w_addr_o));
      else check("w_burst", pack(w_addr_o, w_len_o, w_offset_o, w_tailer_o, w_last_o), exp_w_q.pop_front());
    end
  endtask

  task automatic drain(input string name, input logic rand_ready);
    int n = 0;
    do begin
      next_cycle();
      r_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      w_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      observe();
      n++;
    end while ((exp_r_q.size() != 0 || exp_w_q.size() != 0 || r_busy_o || w_busy_o) && n < 400);
    if (n >= 400) fail(name, "timeout waiting for expected bursts");
  endtask

  task automatic wait_first(input string name, output int cycles);
    cycles = 0;
    do begin
      next_cycle();
      observe();
      cycles++;
    end while (!r_seen && cycles < 20);
    if (!r_seen) fail(name, "no read burst within 20 cycles");
  endtask

  task automatic run_vec(input int k);
    foreach (bt[i]) begin
      if (bt[i].id == k) begin
        if (bt[i].is_w) exp_w_q.push_back(pack(bt[i].addr, bt[i].len, bt[i].off, bt[i].tail, bt[i].last));
        else            exp_r_q.push_back(pack(bt[i].addr, bt[i].len, bt[i].off, bt[i].tail, bt[i].last));
      end
    end
    next_cycle();
    push_req(rt[k].length, rt[k].src, rt[k].dst, rt[k].dec);
    observe();
    check("vec_req_ready", req_ready_o, 1);
    drain($sformatf("vec%0d", k), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, first, second, nv;
`ifdef IDMA_LEGALIZER_ZERO_LEN_EN
    int zp;
`endif
    // Request table and hand-computed bursts (B = 128, 8-byte beats)
    rt[0] = '{length: 300, src: 32'h10, dst: 32'h10, dec: 1'b0};
    rt[1] = '{length: 64,  src: 32'h04, dst: 32'h40, dec: 1'b1};
    rt[2] = '{length: 1,   src: 32'h07, dst: 32'h07, dec: 1'b0};
    rt[3] = '{length: 200, src: 32'h70, dst: 32'h08, dec: 1'b0};
    rt[4] = '{length: 20,  src: 32'h7D, dst: 32'h103, dec: 1'b1};
    for (int s = 0; s < 2; s++) begin
      add_burst(0, s[0], 32'h010, 8'd13, 3'd0, 3'd0, 1'b0);
      add_burst(0, s[0], 32'h080, 8'd15, 3'd0, 3'd0, 1'b0);
      add_burst(0, s[0], 32'h100, 8'd7,  3'd0, 3'd4, 1'b1);
      add_burst(2, s[0], 32'h000, 8'd0,  3'd7, 3'd0, 1'b1);
    end
    add_burst(1, 1'b0, 32'h00, 8'd8, 3'd4, 3'd4, 1'b1);
    add_burst(1, 1'b1, 32'h40, 8'd7, 3'd0, 3'd0, 1'b1);
    add_burst(3, 1'b0, 32'h070, 8'd1,  3'd0, 3'd0, 1'b0);
    add_burst(3, 1'b0, 32'h080, 8'd12, 3'd0, 3'd0, 1'b0);
    add_burst(3, 1'b0, 32'h0E8, 8'd2,  3'd0, 3'd0, 1'b0);
    add_burst(3, 1'b0, 32'h100, 8'd6,  3'd0, 3'd0, 1'b1);
    add_burst(3, 1'b1, 32'h008, 8'd1,  3'd0, 3'd0, 1'b0);
    add_burst(3, 1'b1, 32'h018, 8'd12, 3'd0, 3'd0, 1'b0);
    add_burst(3, 1'b1, 32'h080, 8'd2,  3'd0, 3'd0, 1'b0);
    add_burst(3, 1'b1, 32'h098, 8'd6,  3'd0, 3'd0, 1'b1);
    add_burst(4, 1'b0, 32'h078, 8'd0, 3'd5, 3'd0, 1'b0);
    add_burst(4, 1'b0, 32'h080, 8'd2, 3'd0, 3'd1, 1'b1);
    add_burst(4, 1'b1, 32'h100, 8'd2, 3'd3, 3'd7, 1'b1);

    // Reset state
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("rst_req_ready", req_ready_o, 1);
    check("rst_r_valid", r_valid_o, 0);
    check("rst_w_valid", w_valid_o, 0);
    check("rst_r_busy", r_busy_o, 0);
    check("rst_w_busy", w_busy_o, 0);
    check("rst_r_last", r_last_o, 0);
    check("rst_w_last", w_last_o, 0);

    for (int k = 0; k < 5; k++) run_vec(k);
    r_ready_i = 1'b1;
    w_ready_i = 1'b1;

    // Back-to-back requests: no idle cycle between them
    expect_pair(32'h400, 32'h500, 8'd0, 3'd0, 1'b1);
    expect_pair(32'h408, 32'h508, 8'd0, 3'd0, 1'b1);
    next_cycle(); push_req(8, 32'h400, 32'h500, 1'b0); observe();
    next_cycle(); push_req(8, 32'h408, 32'h508, 1'b0); observe();
    first = -1; second = -1; nv = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      observe();
      if (r_seen) begin
        nv++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check("b2b_count", nv, 2);
    check("b2b_gap", second - first, 1);
    check("b2b_first_latency", first, 0);

    // Kill after the first burst, second request queued
    expect_pair(32'h010, 32'h010, 8'd13, 3'd0, 1'b0);
    expect_pair(32'h200, 32'h300, 8'd0, 3'd0, 1'b1);
    next_cycle(); push_req(300, 32'h10, 32'h10, 1'b0); observe();
    next_cycle(); push_req(8, 32'h200, 32'h300, 1'b0); observe();
    wait_first("kill_first", c);
    next_cycle(); kill_i = 1'b1; r_ready_i = 1'b0; w_ready_i = 1'b0; observe();
    next_cycle(); kill_i = 1'b0; r_ready_i = 1'b1; w_ready_i = 1'b1; observe();
    check("kill_r_busy", r_busy_o, 0);
    check("kill_w_busy", w_busy_o, 0);
    wait_first("kill_next", c);
    check("kill_next_latency", c, 1);
    drain("kill_drain", 1'b0);

    // Flush for 5 cycles mid-transfer, with a push accepted during the flush
    expect_pair(32'h010, 32'h010, 8'd13, 3'd0, 1'b0);
    expect_pair(32'h080, 32'h080, 8'd15, 3'd0, 1'b0);
    expect_pair(32'h100, 32'h100, 8'd7, 3'd4, 1'b1);
    expect_pair(32'h600, 32'h700, 8'd0, 3'd0, 1'b1);
    next_cycle(); push_req(300, 32'h10, 32'h10, 1'b0); observe();
    wait_first("flush_first", c);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      flush_i = 1'b1;
      if (i == 2) push_req(8, 32'h600, 32'h700, 1'b0);
      observe();
      check("flush_r_valid", r_valid_o, 0);
      check("flush_w_valid", w_valid_o, 0);
      check("flush_busy", r_busy_o, 1);
      if (i == 2) check("flush_push_ready", req_ready_o, 1);
    end
    next_cycle(); flush_i = 1'b0; observe();
    check("flush_resume", r_seen, 1);
    drain("flush_drain", 1'b0);

    // Fill the FIFO while the sides are stalled
    r_ready_i = 1'b0;
    w_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_pair(32'h800 + 32'(8 * i), 32'h900 + 32'(8 * i), 8'd0, 3'd0, 1'b1);
      next_cycle(); push_req(8, 32'h800 + 32'(8 * i), 32'h900 + 32'(8 * i), 1'b0); observe();
    end
    next_cycle(); observe();
    check("full_req_ready", req_ready_o, 0);
    check("full_busy", r_busy_o, 1);
    drain("full_drain", 1'b0);
    check("full_ready_after", req_ready_o, 1);

    // Zero-length request
`ifdef IDMA_LEGALIZER_ZERO_LEN_EN
    zp = 0; nv = 0;
    next_cycle(); push_req(0, 32'h20, 32'h30, 1'b0); observe();
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      observe();
      if (zero_len_o) zp++;
      if (r_seen || w_seen) nv++;
    end
    check("zero_len_pulses", zp, 1);
    check("zero_len_valids", nv, 0);
    check("zero_len_busy", r_busy_o, 0);
`else
    expect_pair(32'h20, 32'h30, 8'd0, 3'd0, 1'b1);
    next_cycle(); push_req(0, 32'h20, 32'h30, 1'b0); observe();
    drain("zero_len", 1'b0);
`endif
    check("final_r_left", exp_r_q.size(), 0);
    check("final_w_left", exp_w_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
